// File: rtl/ascon_block_feeder_if.sv
//------------------------------------------------------------------------------
// Module   : ascon_block_feeder_if
// Brief    : Byte-stream input and Ascon block output bundle for the feeder.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface ascon_block_feeder_if #(
  parameter int pBLK_WIDTH = 128,
  parameter int pCNT_WIDTH = 16
);
  logic [7:0]            in_data_i;
  logic                  in_valid_i;
  logic                  in_last_i;
  logic                  in_eot_i;
  logic                  in_empty_i;
  logic                  in_ready_o;
  logic [pBLK_WIDTH-1:0] blk_data_o;
  logic                  blk_valid_o;
  logic                  blk_last_o;
  logic                  blk_eot_o;
  logic [4:0]            blk_valid_bytes_o;
  logic                  blk_ready_i;
  logic [pCNT_WIDTH-1:0] blk_count_o;
  logic                  err_o;

  modport slave (
    input  in_data_i, in_valid_i, in_last_i, in_eot_i, in_empty_i, blk_ready_i,
    output in_ready_o, blk_data_o, blk_valid_o, blk_last_o, blk_eot_o,
           blk_valid_bytes_o, blk_count_o, err_o
  );

  modport master (
    output in_data_i, in_valid_i, in_last_i, in_eot_i, in_empty_i, blk_ready_i,
    input  in_ready_o, blk_data_o, blk_valid_o, blk_last_o, blk_eot_o,
           blk_valid_bytes_o, blk_count_o, err_o
  );
endinterface

`default_nettype wire

// File: rtl/ascon_block_feeder.sv
//------------------------------------------------------------------------------
// Module   : ascon_block_feeder
// Brief    : Packs a segmented byte stream into 128-bit big-endian Ascon blocks
//            behind a 2-entry FIFO. Define ASCON_FEEDER_PAD_EN to insert Ascon
//            0x80 padding (including an extra pad block after a full last block).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ascon_block_feeder #(
  parameter int pBLK_WIDTH = 128,
  parameter int pCNT_WIDTH = 16
) (
  input  wire logic           crypto_clk,
  input  wire logic           reset_i,
  ascon_block_feeder_if.slave bus
);

  localparam logic [pBLK_WIDTH-1:0] c_PAD_BLOCK = {8'h80, {(pBLK_WIDTH-8){1'b0}}};

  typedef struct packed {
    logic [pBLK_WIDTH-1:0] data;
    logic                  last;
    logic                  eot;
    logic [4:0]            vb;
  } blk_t;

`ifdef ASCON_FEEDER_PAD_EN
  typedef enum logic [0:0] {ST_FILL = 1'b0, ST_PAD = 1'b1} state_t;
`else
  typedef enum logic [0:0] {ST_FILL = 1'b0} state_t;
`endif

  state_t                r_state;
  state_t                w_state_nxt;
  logic [pBLK_WIDTH-1:0] r_asm;
  logic [pBLK_WIDTH-1:0] w_asm_nxt;
  logic [3:0]            r_byte_cnt;
  logic [3:0]            w_cnt_nxt;
  logic                  r_pad_eot;
  logic                  w_pad_eot_nxt;
  blk_t                  r_fifo [2];
  logic                  r_rd_ptr;
  logic                  r_wr_ptr;
  logic [1:0]            r_fifo_cnt;
  logic [pCNT_WIDTH-1:0] r_blk_cnt;
  logic                  r_err;

  logic                  w_in_ready;
  logic                  w_acc_byte;
  logic                  w_acc_empty;
  logic                  w_blk_full;
  logic [4:0]            w_cnt_inc;
  logic [pBLK_WIDTH-1:0] w_asm_byte;
  logic                  w_push;
  blk_t                  w_push_blk;
  logic                  w_pop;
  logic                  w_err_set;

  assign w_in_ready  = (r_fifo_cnt != 2'd2) && (r_state == ST_FILL);
  assign w_acc_byte  = bus.in_valid_i & w_in_ready;
  // A byte and an empty-segment pulse in the same cycle: the byte wins.
  assign w_acc_empty = bus.in_empty_i & ~bus.in_valid_i & w_in_ready;
  assign w_blk_full  = w_acc_byte && (r_byte_cnt == 4'hF);
  assign w_cnt_inc   = {1'b0, r_byte_cnt} + 5'd1;
  assign w_asm_byte  = r_asm |
                       ({bus.in_data_i, {(pBLK_WIDTH-8){1'b0}}} >> {r_byte_cnt, 3'b000});
  assign w_pop       = (r_fifo_cnt != 2'd0) & bus.blk_ready_i;

  always_comb begin
    w_state_nxt   = r_state;
    w_asm_nxt     = r_asm;
    w_cnt_nxt     = r_byte_cnt;
    w_pad_eot_nxt = r_pad_eot;
    w_push        = 1'b0;
    w_push_blk    = '0;
    w_err_set     = (bus.in_valid_i | bus.in_empty_i) & ~w_in_ready;

    case (r_state)
      ST_FILL: begin
        if (w_acc_byte) begin
          if (w_blk_full) begin
            w_push          = 1'b1;
            w_push_blk.data = w_asm_byte;
            w_push_blk.vb   = 5'd16;
            w_push_blk.last = bus.in_last_i;
            w_push_blk.eot  = bus.in_eot_i & bus.in_last_i;
`ifdef ASCON_FEEDER_PAD_EN
            // A segment ending on a block boundary needs a separate pad block.
            if (bus.in_last_i) begin
              w_push_blk.last = 1'b0;
              w_push_blk.eot  = 1'b0;
              w_pad_eot_nxt   = bus.in_eot_i;
              w_state_nxt     = ST_PAD;
            end
`endif
            w_asm_nxt = '0;
            w_cnt_nxt = 4'd0;
          end else if (bus.in_last_i) begin
            w_push          = 1'b1;
            w_push_blk.data = w_asm_byte;
`ifdef ASCON_FEEDER_PAD_EN
            w_push_blk.data = w_asm_byte | (c_PAD_BLOCK >> {w_cnt_inc, 3'b000});
`endif
            w_push_blk.vb   = w_cnt_inc;
            w_push_blk.last = 1'b1;
            w_push_blk.eot  = bus.in_eot_i;
            w_asm_nxt       = '0;
            w_cnt_nxt       = 4'd0;
          end else begin
            w_asm_nxt = w_asm_byte;
            w_cnt_nxt = w_cnt_inc[3:0];
          end
        end else if (w_acc_empty) begin
          if (r_byte_cnt == 4'd0) begin
            w_push          = 1'b1;
`ifdef ASCON_FEEDER_PAD_EN
            w_push_blk.data = c_PAD_BLOCK;
`endif
            w_push_blk.vb   = 5'd0;
            w_push_blk.last = 1'b1;
            w_push_blk.eot  = bus.in_eot_i;
          end else begin
            w_err_set = 1'b1;
          end
        end
      end
`ifdef ASCON_FEEDER_PAD_EN
      ST_PAD: begin
        if (r_fifo_cnt != 2'd2) begin
          w_push          = 1'b1;
          w_push_blk.data = c_PAD_BLOCK;
          w_push_blk.vb   = 5'd0;
          w_push_blk.last = 1'b1;
          w_push_blk.eot  = r_pad_eot;
          w_state_nxt     = ST_FILL;
        end
      end
`endif
      default: w_state_nxt = ST_FILL;
    endcase
  end

  always_ff @(posedge crypto_clk) begin
    if (reset_i) begin
      r_state    <= ST_FILL;
      r_asm      <= '0;
      r_byte_cnt <= 4'd0;
      r_pad_eot  <= 1'b0;
      r_fifo[0]  <= '0;
      r_fifo[1]  <= '0;
      r_rd_ptr   <= 1'b0;
      r_wr_ptr   <= 1'b0;
      r_fifo_cnt <= 2'd0;
      r_blk_cnt  <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_asm      <= w_asm_nxt;
      r_byte_cnt <= w_cnt_nxt;
      r_pad_eot  <= w_pad_eot_nxt;
      // Popped slots are cleared so idle outputs read as zero; a push never
      // targets the slot being popped because that needs an empty or full FIFO.
      if (w_pop) begin
        r_fifo[r_rd_ptr] <= '0;
        r_rd_ptr         <= ~r_rd_ptr;
        if (r_blk_cnt != {pCNT_WIDTH{1'b1}}) begin
          r_blk_cnt <= r_blk_cnt + 1'b1;
        end
      end
      if (w_push) begin
        r_fifo[r_wr_ptr] <= w_push_blk;
        r_wr_ptr         <= ~r_wr_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_fifo_cnt <= r_fifo_cnt + 2'd1;
        2'b01:   r_fifo_cnt <= r_fifo_cnt - 2'd1;
        default: r_fifo_cnt <= r_fifo_cnt;
      endcase
      if (w_err_set) begin
        r_err <= 1'b1;
      end
    end
  end

  assign bus.in_ready_o        = w_in_ready;
  assign bus.blk_valid_o       = (r_fifo_cnt != 2'd0);
  assign bus.blk_data_o        = r_fifo[r_rd_ptr].data;
  assign bus.blk_last_o        = r_fifo[r_rd_ptr].last;
  assign bus.blk_eot_o         = r_fifo[r_rd_ptr].eot;
  assign bus.blk_valid_bytes_o = r_fifo[r_rd_ptr].vb;
  assign bus.blk_count_o       = r_blk_cnt;
  assign bus.err_o             = r_err;

endmodule

`default_nettype wire
